// File: rtl/dram_lane_model_if.sv
// Request/response bundle between the datapath (master) and the DRAM lane model (slave).
interface dram_lane_model_if #(
    parameter int unsigned LANES  = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
);
    logic                       req_valid;
    logic                       req_ready;
    logic [LANES-1:0]           req_en;
    logic                       req_rdwr;
    logic [LANES*ADDR_W-1:0]    req_addr;
    logic [LANES*DATA_W-1:0]    req_wdata;
    logic [LANES-1:0]           rsp_valid;
    logic                       rsp_rdwr;
    logic [LANES*DATA_W-1:0]    rsp_rdata;

    modport master (
        output req_valid, req_en, req_rdwr, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdwr, rsp_rdata
    );

    modport slave (
        input  req_valid, req_en, req_rdwr, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdwr, rsp_rdata
    );
endinterface

// File: rtl/dram_lane_model.sv
// Multi-lane DRAM model: one request at a time, every enabled lane answered after WAIT_CYCLES.
module dram_lane_model #(
    parameter int unsigned LANES       = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned WAIT_CYCLES = 20
) (
    input  logic               clk,
    input  logic               reset,
    dram_lane_model_if.slave   bus
);
    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam logic [7:0]  CNT_LAST = 8'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_REPLY} state_t;

    state_t                   state_q, state_d;
    logic [7:0]               cnt_q, cnt_d;
    logic                     accept, enter_reply;

    logic [LANES-1:0]         en_q;
    logic                     rdwr_q;
    logic [LANES*ADDR_W-1:0]  addr_q;
    logic [LANES*DATA_W-1:0]  wdata_q;

    logic [LANES-1:0]         rsp_valid_q;
    logic                     rsp_rdwr_q;
    logic [LANES*DATA_W-1:0]  rsp_rdata_q, rd_d;

    logic [DATA_W-1:0]        mem_q [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        enter_reply = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && |bus.req_en) begin
                    accept  = 1'b1;
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d     = ST_REPLY;
                    enter_reply = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_REPLY: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q    <= '0;
            rdwr_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            en_q    <= bus.req_en;
            rdwr_q  <= bus.req_rdwr;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    always_comb begin
        rd_d = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (en_q[i] && rdwr_q)
                rd_d[i*DATA_W +: DATA_W] = mem_q[addr_q[i*ADDR_W +: ADDR_W]];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= '0;
            rsp_rdwr_q  <= 1'b0;
            rsp_rdata_q <= '0;
        end else if (enter_reply) begin
            rsp_valid_q <= en_q;
            rsp_rdwr_q  <= rdwr_q;
            rsp_rdata_q <= rd_d;
        end else if (state_q == ST_REPLY) begin
            rsp_valid_q <= '0;
            rsp_rdwr_q  <= 1'b0;
            rsp_rdata_q <= '0;
        end
    end

    // Lanes are visited in ascending order, so the last NBA (highest lane) wins on an address clash.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned j = 0; j < DEPTH; j++)
                mem_q[j] <= '0;
        end else if (enter_reply && !rdwr_q) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (en_q[i])
                    mem_q[addr_q[i*ADDR_W +: ADDR_W]] <= wdata_q[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdwr  = rsp_rdwr_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_dram_lane_model.sv
// Bench for dram_lane_model: default 8-lane instance and a 4x32-bit, 1-cycle-wait instance.
module tb_dram_lane_model;
    localparam int WA = 20;
    localparam int WB = 1;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    dram_lane_model_if #(.LANES(8), .DATA_W(8), .ADDR_W(6)) ifa ();
    dram_lane_model_if #(.LANES(4), .DATA_W(32), .ADDR_W(10)) ifb ();

    dram_lane_model #(.LANES(8), .DATA_W(8), .ADDR_W(6), .WAIT_CYCLES(WA))
        dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
    dram_lane_model #(.LANES(4), .DATA_W(32), .ADDR_W(10), .WAIT_CYCLES(WB))
        dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [7:0]  ref_a [64];
    logic [31:0] ref_b [1024];

    logic [47:0]  aa;
    logic [63:0]  da;
    logic [39:0]  ab;
    logic [127:0] db;
    logic [7:0]   ea;
    logic [3:0]   eb;
    bit           seen;
    int           k;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction on instance A: junk is driven on req_* throughout the wait to prove it is ignored.
    task automatic txn_a(input string tag, input logic [7:0] en, input logic rdwr,
                         input logic [47:0] addr, input logic [63:0] wdata);
        logic [63:0] exp_rd;
        int          n;
        bit          busy_ok;
        exp_rd = '0;
        for (int i = 0; i < 8; i++)
            if (en[i] && rdwr) exp_rd[i*8 +: 8] = ref_a[addr[i*6 +: 6]];
        n = 0;
        while (!ifa.req_ready && n < 100) begin @(negedge clk); n++; end
        check({tag, " ready_before"}, ifa.req_ready, 1'b1);
        ifa.req_valid = 1'b1; ifa.req_en = en; ifa.req_rdwr = rdwr;
        ifa.req_addr  = addr; ifa.req_wdata = wdata;
        @(negedge clk);
        n = 1; busy_ok = 1'b1;
        while (!(|ifa.rsp_valid) && n < 300) begin
            if (ifa.req_ready) busy_ok = 1'b0;
            ifa.req_valid = 1'($urandom_range(0, 1));
            ifa.req_en    = 8'($urandom);
            ifa.req_rdwr  = 1'($urandom_range(0, 1));
            ifa.req_addr  = {16'($urandom), $urandom};
            ifa.req_wdata = {$urandom, $urandom};
            @(negedge clk); n++;
        end
        ifa.req_valid = 1'b0;
        check({tag, " latency"}, n, WA + 1);
        check({tag, " busy_in_wait"}, busy_ok, 1'b1);
        check({tag, " ready_in_reply"}, ifa.req_ready, 1'b0);
        check({tag, " rsp_valid"}, ifa.rsp_valid, en);
        check({tag, " rsp_rdwr"}, ifa.rsp_rdwr, rdwr);
        check({tag, " rsp_rdata"}, ifa.rsp_rdata, exp_rd);
        @(negedge clk);
        check({tag, " ready_after"}, ifa.req_ready, 1'b1);
        check({tag, " valid_drop"}, ifa.rsp_valid, 8'h00);
        if (!rdwr)
            for (int i = 0; i < 8; i++)
                if (en[i]) ref_a[addr[i*6 +: 6]] = wdata[i*8 +: 8];
    endtask

    task automatic txn_b(input string tag, input logic [3:0] en, input logic rdwr,
                         input logic [39:0] addr, input logic [127:0] wdata);
        logic [127:0] exp_rd;
        int           n;
        exp_rd = '0;
        for (int i = 0; i < 4; i++)
            if (en[i] && rdwr) exp_rd[i*32 +: 32] = ref_b[addr[i*10 +: 10]];
        n = 0;
        while (!ifb.req_ready && n < 100) begin @(negedge clk); n++; end
        ifb.req_valid = 1'b1; ifb.req_en = en; ifb.req_rdwr = rdwr;
        ifb.req_addr  = addr; ifb.req_wdata = wdata;
        @(negedge clk);
        ifb.req_valid = 1'b0;
        n = 1;
        while (!(|ifb.rsp_valid) && n < 50) begin @(negedge clk); n++; end
        check({tag, " latency"}, n, WB + 1);
        check({tag, " rsp_valid"}, ifb.rsp_valid, en);
        check({tag, " rsp_rdwr"}, ifb.rsp_rdwr, rdwr);
        check({tag, " rsp_rdata"}, ifb.rsp_rdata, exp_rd);
        @(negedge clk);
        check({tag, " ready_after"}, ifb.req_ready, 1'b1);
        if (!rdwr)
            for (int i = 0; i < 4; i++)
                if (en[i]) ref_b[addr[i*10 +: 10]] = wdata[i*32 +: 32];
    endtask

    initial begin
        for (int i = 0; i < 64; i++)   ref_a[i] = '0;
        for (int i = 0; i < 1024; i++) ref_b[i] = '0;
        ifa.req_valid = 1'b0; ifa.req_en = '0; ifa.req_rdwr = 1'b0; ifa.req_addr = '0; ifa.req_wdata = '0;
        ifb.req_valid = 1'b0; ifb.req_en = '0; ifb.req_rdwr = 1'b0; ifb.req_addr = '0; ifb.req_wdata = '0;
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (3) @(negedge clk);
        check("reset ready", ifa.req_ready, 1'b1);
        check("reset rsp_valid", ifa.rsp_valid, 8'h00);
        check("reset rsp_rdwr", ifa.rsp_rdwr, 1'b0);
        check("reset rsp_rdata", ifa.rsp_rdata, 64'h0);
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
        check("post-reset ready", ifa.req_ready, 1'b1);

        for (int i = 0; i < 8; i++) aa[i*6 +: 6] = 6'(i);
        txn_a("read_all", 8'hFF, 1'b1, aa, 64'h0);

        aa = '0; da = '0;
        aa[0*6 +: 6] = 6'd5;  da[0*8 +: 8] = 8'hA5;
        aa[3*6 +: 6] = 6'd63; da[3*8 +: 8] = 8'h3C;
        txn_a("write_0_3", 8'h09, 1'b0, aa, da);
        aa = '0;
        aa[0*6 +: 6] = 6'd5; aa[1*6 +: 6] = 6'd63;
        txn_a("readback", 8'h03, 1'b1, aa, 64'h0);

        aa = '0; da = '0;
        aa[2*6 +: 6] = 6'd9; da[2*8 +: 8] = 8'h11;
        aa[6*6 +: 6] = 6'd9; da[6*8 +: 8] = 8'h66;
        txn_a("conflict_wr", 8'h44, 1'b0, aa, da);
        check("conflict model", ref_a[9], 8'h66);
        aa = '0;
        aa[0*6 +: 6] = 6'd9; aa[4*6 +: 6] = 6'd9;
        txn_a("conflict_rd", 8'h11, 1'b1, aa, 64'h0);

        ifa.req_valid = 1'b1; ifa.req_en = '0; ifa.req_rdwr = 1'b0;
        ifa.req_addr = '0; ifa.req_wdata = {$urandom, $urandom};
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (!ifa.req_ready || |ifa.rsp_valid) seen = 1'b1;
        end
        ifa.req_valid = 1'b0;
        check("zero_en ignored", seen, 1'b0);

        for (int t = 0; t < 30; t++) begin
            ea = 8'($urandom_range(1, 255));
            for (int i = 0; i < 8; i++) aa[i*6 +: 6] = 6'($urandom_range(0, 15));
            da = {$urandom, $urandom};
            txn_a("rand_a", ea, 1'($urandom_range(0, 1)), aa, da);
        end

        // Write to addr 20 abandoned by a reset pulse in cycle 10 of its wait.
        aa = '0; aa[0*6 +: 6] = 6'd20; da = 64'h77;
        ifa.req_valid = 1'b1; ifa.req_en = 8'h01; ifa.req_rdwr = 1'b0;
        ifa.req_addr = aa; ifa.req_wdata = da;
        @(negedge clk);
        ifa.req_valid = 1'b0;
        k = 1;
        while (k < 10) begin @(negedge clk); k++; end
        #2 rst_a = 1'b0;
        #1 check("async reset ready", ifa.req_ready, 1'b1);
        @(negedge clk);
        rst_a = 1'b1;
        for (int i = 0; i < 64; i++) ref_a[i] = '0;
        seen = 1'b0;
        repeat (WA + 5) begin
            @(negedge clk);
            if (|ifa.rsp_valid) seen = 1'b1;
        end
        check("abandoned no rsp", seen, 1'b0);
        aa = '0; aa[0*6 +: 6] = 6'd20; aa[1*6 +: 6] = 6'd5;
        txn_a("after_reset_rd", 8'h03, 1'b1, aa, 64'h0);

        check("b reset ready", ifb.req_ready, 1'b1);
        for (int i = 0; i < 4; i++) ab[i*10 +: 10] = 10'(1020 + i);
        txn_b("b_read_all", 4'hF, 1'b1, ab, 128'h0);
        ab = '0; db = '0;
        ab[2*10 +: 10] = 10'd1023; db[2*32 +: 32] = 32'hDEADBEEF;
        txn_b("b_write", 4'h4, 1'b0, ab, db);
        ab = '0; ab[0*10 +: 10] = 10'd1023;
        txn_b("b_readback", 4'h1, 1'b1, ab, 128'h0);
        check("b model beef", ref_b[1023], 32'hDEADBEEF);
        for (int t = 0; t < 20; t++) begin
            eb = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) ab[i*10 +: 10] = 10'($urandom_range(1020, 1023));
            db = {$urandom, $urandom, $urandom, $urandom};
            txn_b("rand_b", eb, 1'($urandom_range(0, 1)), ab, db);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
